// File: rtl/base3_pkg.sv
// Shared definitions for the ternary/binary converters.
//   state_t       : FSM encodings IDLE/CONV/DONE (code 2'b11 unused)
//   DIGIT_W       : bits per packed ternary digit
//   DIGIT_INVALID : the one unused 2-bit digit code
//   cnt_w()       : digit counter width for a given digit count
package base3_pkg;

  localparam int DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] DIGIT_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/base3_mac.sv
// One Horner step: acc_nxt = acc*3 + digit, done as shift-add.
//   acc      : running accumulator (W bits)
//   digit    : ternary digit code
//   acc_nxt  : updated accumulator, truncated to W bits
//   digit_ok : low when the digit code is the invalid code 2'b11
// With CHECK set, an invalid digit contributes 0; otherwise code 11 is
// taken at face value as 3.
module base3_mac
  import base3_pkg::*;
#(
  parameter int W     = 32,
  parameter bit CHECK = 1'b0
) (
  input  logic [W-1:0]       acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [W-1:0]       acc_nxt,
  output logic               digit_ok
);

  logic [W-1:0] d_ext;

  always_comb begin
    digit_ok = (digit != DIGIT_INVALID);
    d_ext    = W'(digit);
    if (CHECK && !digit_ok) d_ext = '0;
    acc_nxt  = (acc << 1) + acc + d_ext;
  end

endmodule

// File: rtl/base3_to_base2.sv
// Iterative packed-ternary to binary converter (Horner, MSD first,
// one digit per clock).
//   clk, rst_n : clock, asynchronous active-low reset
//   base3_no   : WIDTH packed digits, digit i at [2i+1:2i]
//   en         : start request, sampled only in IDLE
//   base2_no   : registered binary result
//   done       : one-cycle result-valid pulse
//   busy       : high while not in IDLE
//   err        : invalid-digit flag, valid with done
// Optional feature macro: BASE3_DIGIT_CHECK_EN (digit code 11 flagged via
// err and treated as 0). Without it code 11 counts as 3 and err is 0.
//
// Timing: en captured at edge k, the last digit is folded in at edge
// k+WIDTH (CONV->DONE), and the result/done/err are registered on the
// DONE->IDLE edge k+WIDTH+1, so done is high from k+WIDTH+1 to k+WIDTH+2.
// A new capture can happen at k+WIDTH+2, giving a WIDTH+2 cycle period.
module base3_to_base2
  import base3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] base3_no,
  input  logic               en,
  output logic [2*WIDTH-1:0] base2_no,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);

`ifdef BASE3_DIGIT_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  state_t        state, state_nxt;
  logic [AW-1:0] sr;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic          digit_ok;
  logic          last;

  assign last = (cnt == CW'(WIDTH - 1));

  base3_mac #(.W(AW), .CHECK(CHECK)) u_mac (
    .acc      (acc),
    .digit    (sr[AW-1 -: DIGIT_W]),
    .acc_nxt  (acc_nxt),
    .digit_ok (digit_ok)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state; the unused code falls back to IDLE
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = en ? CONV : IDLE;
      CONV:    state_nxt = last ? DONE : CONV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      base2_no <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (en) begin
          sr  <= base3_no;
          acc <= '0;
          cnt <= '0;
        end
        CONV: begin
          acc <= acc_nxt;
          sr  <= sr << DIGIT_W;
          cnt <= cnt + 1'b1;
        end
        DONE: base2_no <= acc;
        default: ;
      endcase
    end
  end

`ifdef BASE3_DIGIT_CHECK_EN
  logic err_int;

  // err_int is sticky across one conversion; err is published with done
  // and holds until the next capture clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_int <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          err_int <= 1'b0;
          err     <= 1'b0;
        end
        CONV: if (!digit_ok) err_int <= 1'b1;
        DONE: err <= err_int;
        default: ;
      endcase
    end
  end
`else
  logic unused_ok;
  assign unused_ok = digit_ok;
  assign err       = 1'b0;
`endif

endmodule
